// File: rtl/sop_error_sweeper.sv
// Exhaustive error sweeper for small abs_diff approximate netlists: walks every input
// vector, compares the netlist output with an exact |a-b|, and reports error statistics.
module sop_error_sweeper #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 3,
   parameter int ET    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   vec_out,
   input  logic [N_OUT-1:0]  approx_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_OUT-1:0]  max_err,
   output logic [N_IN:0]     viol_cnt,
   output logic [N_IN-1:0]   first_viol_vec,
   output logic              first_viol_valid
);

   localparam int HALF = N_IN / 2;
   localparam logic [N_IN-1:0] LAST_VEC = '1;
   localparam logic [N_OUT:0]  ET_W     = (N_OUT+1)'(ET);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_d;
   logic [N_IN-1:0]   vec_d, fvv_d;
   logic              busy_d, done_d, pass_d, fvvalid_d;
   logic [N_OUT-1:0]  max_d;
   logic [N_IN:0]     viol_d;

   logic [HALF-1:0]   op_a, op_b, diff;
   logic [N_OUT-1:0]  exact, err;
   logic [N_OUT:0]    err_w;
   logic              violate;

   // Exact reference model, then error widened by one bit so the subtraction cannot wrap
   assign op_a    = vec_out[HALF-1:0];
   assign op_b    = vec_out[N_IN-1:HALF];
   assign diff    = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
   assign exact   = N_OUT'(diff);
   assign err_w   = ({1'b0, exact} >= {1'b0, approx_in}) ? ({1'b0, exact} - {1'b0, approx_in})
                                                         : ({1'b0, approx_in} - {1'b0, exact});
   assign err     = err_w[N_OUT] ? '1 : err_w[N_OUT-1:0];
   assign violate = ({1'b0, err} > ET_W);

   always_comb begin
      state_d   = state;
      vec_d     = vec_out;
      busy_d    = busy;
      done_d    = 1'b0;
      pass_d    = pass;
      max_d     = max_err;
      viol_d    = viol_cnt;
      fvv_d     = first_viol_vec;
      fvvalid_d = first_viol_valid;
      case (state)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               vec_d     = '0;
               busy_d    = 1'b1;
               pass_d    = 1'b0;
               max_d     = '0;
               viol_d    = '0;
               fvv_d     = '0;
               fvvalid_d = 1'b0;
            end
         end
         RUN: begin
            if (err > max_err) max_d = err;
            if (violate) begin
               viol_d = viol_cnt + (N_IN+1)'(1);
               if (!first_viol_valid) begin
                  fvv_d     = vec_out;
                  fvvalid_d = 1'b1;
               end
            end
            if (vec_out != LAST_VEC) begin
               vec_d = vec_out + N_IN'(1);
            end else begin
               // pass must reflect the final vector's own update, hence viol_d
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (viol_d == '0);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         max_err          <= '0;
         viol_cnt         <= '0;
         first_viol_vec   <= '0;
         first_viol_valid <= 1'b0;
      end else begin
         state            <= state_d;
         vec_out          <= vec_d;
         busy             <= busy_d;
         done             <= done_d;
         pass             <= pass_d;
         max_err          <= max_d;
         viol_cnt         <= viol_d;
         first_viol_vec   <= fvv_d;
         first_viol_valid <= fvvalid_d;
      end
   end

endmodule

// File: tb/tb_sop_error_sweeper.sv
// Directed bench for sop_error_sweeper: two instances (ET=2 and ET=1) swept side by side
// against a loopback model or constant approximate outputs.
module tb_sop_error_sweeper;

   logic       clk = 1'b0;
   logic       rst, start;
   logic       mode_loop;
   logic [2:0] const_val;

   logic [3:0] vec_a, vec_b, fvv_a, fvv_b;
   logic [2:0] apx_a, apx_b, max_a, max_b;
   logic [4:0] viol_a, viol_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fvok_a, fvok_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   function automatic logic [2:0] exact_f(input logic [3:0] v);
      logic [1:0] a, b;
      a = v[1:0];
      b = v[3:2];
      return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
   endfunction

   always_comb apx_a = mode_loop ? exact_f(vec_a) : const_val;
   always_comb apx_b = mode_loop ? exact_f(vec_b) : const_val;

   sop_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(2)) dut_a (
      .clk(clk), .rst(rst), .start(start), .vec_out(vec_a), .approx_in(apx_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .max_err(max_a), .viol_cnt(viol_a),
      .first_viol_vec(fvv_a), .first_viol_valid(fvok_a));

   sop_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(1)) dut_b (
      .clk(clk), .rst(rst), .start(start), .vec_out(vec_b), .approx_in(apx_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .max_err(max_b), .viol_cnt(viol_b),
      .first_viol_vec(fvv_b), .first_viol_valid(fvok_b));

   wire [13:0] res_a = {max_a, viol_a, fvv_a, fvok_a, pass_a};
   wire [13:0] res_b = {max_b, viol_b, fvv_b, fvok_b, pass_b};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulses start, then steps until done (bounded); reports latency, busy cycles and vector order errors
   task automatic run_sweep(input int repulse_at, output int lat, output int busy_cyc,
                            output int ord_err);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; busy_cyc = 0; ord_err = 0;
      while (!done_a && lat < 40) begin
         if (busy_a && busy_b) busy_cyc++;
         if (vec_a != lat[3:0] || vec_b != lat[3:0]) ord_err++;
         if (lat == repulse_at) start = 1'b1;
         tick();
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0;
      tick(); tick();
      n_chk++;
      if ({vec_a, busy_a, done_a, res_a} !== 19'd0)
         $display("FAIL reset_a: got %h want 0", {vec_a, busy_a, done_a, res_a});
      else n_pass++;
      n_chk++;
      if ({vec_b, busy_b, done_b, res_b} !== 19'd0)
         $display("FAIL reset_b: got %h want 0", {vec_b, busy_b, done_b, res_b});
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_loopback;
      int lat, bc, oe;
      mode_loop = 1'b1;
      run_sweep(-1, lat, bc, oe);
      n_chk++;
      if (lat !== 16 || bc !== 16 || oe !== 0)
         $display("FAIL loop_timing: lat=%0d busy=%0d ord_err=%0d want 16/16/0", lat, bc, oe);
      else n_pass++;
      n_chk++;
      if (done_b !== 1'b1 || busy_a !== 1'b0)
         $display("FAIL loop_done: done_b=%b busy_a=%b want 1/0", done_b, busy_a);
      else n_pass++;
      n_chk++;
      if (res_a !== {3'd0, 5'd0, 4'd0, 1'b0, 1'b1} || res_b !== {3'd0, 5'd0, 4'd0, 1'b0, 1'b1})
         $display("FAIL loop_results: a=%h b=%h want 0001 0001", res_a, res_b);
      else n_pass++;
      tick();
      n_chk++;
      if (done_a !== 1'b0 || pass_a !== 1'b1 || busy_a !== 1'b0)
         $display("FAIL loop_pulse: done=%b pass=%b busy=%b want 0/1/0", done_a, pass_a, busy_a);
      else n_pass++;
   endtask

   task automatic test_tie1;
      int lat, bc, oe;
      mode_loop = 1'b0; const_val = 3'b001;
      run_sweep(-1, lat, bc, oe);
      n_chk++;
      if (lat !== 16 || oe !== 0)
         $display("FAIL tie1_timing: lat=%0d ord_err=%0d want 16/0", lat, oe);
      else n_pass++;
      n_chk++;
      if (res_a !== {3'd2, 5'd0, 4'd0, 1'b0, 1'b1})
         $display("FAIL tie1_et2: got %h want %h", res_a, {3'd2, 5'd0, 4'd0, 1'b0, 1'b1});
      else n_pass++;
      n_chk++;
      if (res_b !== {3'd2, 5'd2, 4'd3, 1'b1, 1'b0})
         $display("FAIL tie1_et1: got %h want %h", res_b, {3'd2, 5'd2, 4'd3, 1'b1, 1'b0});
      else n_pass++;
      tick();
   endtask

   task automatic test_tie0;
      int lat, bc, oe;
      mode_loop = 1'b0; const_val = 3'b000;
      run_sweep(-1, lat, bc, oe);
      n_chk++;
      if (lat !== 16 || bc !== 16)
         $display("FAIL tie0_timing: lat=%0d busy=%0d want 16/16", lat, bc);
      else n_pass++;
      n_chk++;
      if (res_a !== {3'd3, 5'd2, 4'd3, 1'b1, 1'b0})
         $display("FAIL tie0_et2: got %h want %h", res_a, {3'd3, 5'd2, 4'd3, 1'b1, 1'b0});
      else n_pass++;
      n_chk++;
      if (res_b !== {3'd3, 5'd6, 4'd2, 1'b1, 1'b0})
         $display("FAIL tie0_et1: got %h want %h", res_b, {3'd3, 5'd6, 4'd2, 1'b1, 1'b0});
      else n_pass++;
      tick();
      tick();
      n_chk++;
      if (res_a !== {3'd3, 5'd2, 4'd3, 1'b1, 1'b0} || busy_a !== 1'b0)
         $display("FAIL tie0_hold: got %h busy=%b want %h/0", res_a, busy_a,
                  {3'd3, 5'd2, 4'd3, 1'b1, 1'b0});
      else n_pass++;
   endtask

   task automatic test_repulse;
      int lat, bc, oe;
      mode_loop = 1'b0; const_val = 3'b000;
      run_sweep(4, lat, bc, oe);
      n_chk++;
      if (lat !== 16 || bc !== 16 || oe !== 0)
         $display("FAIL repulse_timing: lat=%0d busy=%0d ord_err=%0d want 16/16/0", lat, bc, oe);
      else n_pass++;
      n_chk++;
      if (res_a !== {3'd3, 5'd2, 4'd3, 1'b1, 1'b0} || res_b !== {3'd3, 5'd6, 4'd2, 1'b1, 1'b0})
         $display("FAIL repulse_results: a=%h b=%h", res_a, res_b);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back;
      int lat, bc, oe;
      mode_loop = 1'b1;
      start = 1'b1;
      tick();
      lat = 0;
      while (!done_a && lat < 40) begin
         tick();
         lat++;
      end
      // start still high: DONE ignores it, IDLE then accepts it
      n_chk++;
      if (lat !== 16 || done_a !== 1'b1)
         $display("FAIL b2b_first: lat=%0d done=%b want 16/1", lat, done_a);
      else n_pass++;
      tick();
      n_chk++;
      if (busy_a !== 1'b0 || done_a !== 1'b0)
         $display("FAIL b2b_idle: busy=%b done=%b want 0/0", busy_a, done_a);
      else n_pass++;
      tick();
      start = 1'b0;
      n_chk++;
      if (busy_a !== 1'b1 || vec_a !== 4'd0 || pass_a !== 1'b0)
         $display("FAIL b2b_restart: busy=%b vec=%0d pass=%b want 1/0/0", busy_a, vec_a, pass_a);
      else n_pass++;
      lat = 0;
      while (!done_a && lat < 40) begin
         tick();
         lat++;
      end
      n_chk++;
      if (lat !== 16 || pass_a !== 1'b1)
         $display("FAIL b2b_second: lat=%0d pass=%b want 16/1", lat, pass_a);
      else n_pass++;
      tick();
   endtask

   task automatic test_rst_mid;
      int lat, bc, oe, seen;
      mode_loop = 1'b0; const_val = 3'b000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if ({vec_a, busy_a, done_a, res_a} !== 19'd0 || {vec_b, busy_b, done_b, res_b} !== 19'd0)
         $display("FAIL rst_mid_clear: a=%h b=%h want 0", {vec_a, busy_a, done_a, res_a},
                  {vec_b, busy_b, done_b, res_b});
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (done_a || busy_a || done_b || busy_b) seen++;
         tick();
      end
      n_chk++;
      if (seen !== 0)
         $display("FAIL rst_mid_quiet: activity cycles=%0d want 0", seen);
      else n_pass++;
      run_sweep(-1, lat, bc, oe);
      n_chk++;
      if (lat !== 16 || oe !== 0 || res_a !== {3'd3, 5'd2, 4'd3, 1'b1, 1'b0} ||
          res_b !== {3'd3, 5'd6, 4'd2, 1'b1, 1'b0})
         $display("FAIL rst_mid_fresh: lat=%0d ord_err=%0d a=%h b=%h", lat, oe, res_a, res_b);
      else n_pass++;
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode_loop = 1'b1; const_val = 3'd0;
      test_reset();
      test_loopback();
      test_tie1();
      test_tie0();
      test_repulse();
      test_back_to_back();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
